button_scan_arbiter: RTL and testbench

//  Shares one debounce time base across N push-buttons. Synchronises and debounces each input.

---
 rtl/button_pkg.sv | 44 ++++
 rtl/button_scan_arbiter_fifo.sv | 79 +++++++
 rtl/button_scan_arbiter.sv | 185 ++++++++++++++++++
 tb/tb_button_scan_arbiter.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/button_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : button_pkg
//  Description : Shared definitions for the button scan arbiter: integer
//                ceil-log2 helper, event encoding width, and the default
//                sample-tick dividers for hardware and short simulations.
//  Revision    : 1.0  initial release
// ============================================================================
package button_pkg;

    // 10 ms sample period at 50 MHz.
    localparam int CLK_DIV_DEFAULT = 500000;
    // Short tick used by simulation builds.
    localparam int SIM_DIV_DEFAULT = 5;
    // Widest button index the event struct below can carry.
    localparam int EVT_ID_MAX_W    = 8;

    // Event as seen by the consumer: which button, and press (1) / release (0).
    // The FIFO stores the same fields packed as {id, press} at the exact
    // width returned by event_width().
    typedef struct packed {
        logic [EVT_ID_MAX_W-1:0] id;
        logic                    press;
    } button_event_t;

    // Smallest r with 2**r >= value (0 for value <= 1).
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

    // Packed {id, press} width for a bank of n buttons.
    function automatic int event_width(input int n);
        return clog2(n) + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/button_scan_arbiter_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : event_fifo
//  Description : Synchronous FIFO holding arbitrated button events.
//                Pointers carry one extra wrap bit so full and empty are
//                distinguished without a separate counter. Writes while full
//                and reads while empty are ignored.
//  Ports       : clk      - clock, rising edge
//                reset    - synchronous, active-high; empties the FIFO
//                push_i   - write data_i this cycle
//                data_i   - entry to write
//                pop_i    - discard head this cycle
//                full_o   - DEPTH entries stored
//                empty_o  - no entries stored
//                head_o   - oldest entry (valid when !empty_o)
//  Revision    : 1.0  initial release
// ============================================================================
module event_fifo
    import button_pkg::*;
#(
    parameter int WIDTH = 3,
    parameter int DEPTH = 4     // power of 2, >= 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic             full_o,
    output logic             empty_o,
    output logic [WIDTH-1:0] head_o
);

    localparam int AW = clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_q, wr_d;
    logic [AW:0]      rd_q, rd_d;
    logic             w_do_push;
    logic             w_do_pop;

    // Same slot, opposite lap -> full; same slot, same lap -> empty.
    assign full_o    = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign empty_o   = (wr_q == rd_q);
    assign head_o    = mem_q[rd_q[AW-1:0]];

    assign w_do_push = push_i && !full_o;
    assign w_do_pop  = pop_i && !empty_o;

    always_comb begin
        wr_d = wr_q;
        rd_d = rd_q;
        if (w_do_push) begin
            wr_d = wr_q + 1'b1;
        end
        if (w_do_pop) begin
            rd_d = rd_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
        end
    end

    // Storage needs no reset: entries are only read between push and pop.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            mem_q[wr_q[AW-1:0]] <= data_i;
        end
    end

endmodule
`default_nettype wire

// File: rtl/button_scan_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : button_scan_arbiter
//  Description : Debounces a bank of N push-buttons on one shared sample
//                tick, converts each debounced edge into a press/release
//                event, and round-robin arbitrates pending events into a
//                small FIFO drained over a valid/ready interface.
//  Ports       : clk         - clock, rising edge
//                reset       - synchronous, active-high
//                ButtonIn    - raw asynchronous button levels [N]
//                ButtonState - debounced level per button [N]
//                EventValid  - FIFO head holds an event
//                EventReady  - consumer accepts the head this cycle
//                EventId     - button index of the head event
//                EventPress  - 1 = press, 0 = release
//                Overflow    - sticky: a pending event was overwritten
//  Revision    : 1.0  initial release
// ============================================================================
module button_scan_arbiter
    import button_pkg::*;
#(
    parameter int N          = 4,
    parameter int CLK_DIV    = CLK_DIV_DEFAULT,
    parameter int SIM_DIV    = SIM_DIV_DEFAULT,
    parameter int sim        = 0,
    parameter int STABLE     = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [N-1:0]        ButtonIn,
    output logic [N-1:0]        ButtonState,
    output logic                EventValid,
    input  logic                EventReady,
    output logic [clog2(N)-1:0] EventId,
    output logic                EventPress,
    output logic                Overflow
);

    localparam int DIV = (sim != 0) ? SIM_DIV : CLK_DIV;
    localparam int CW  = (clog2(DIV) < 1) ? 1 : clog2(DIV);
    localparam int IW  = clog2(N);
    localparam int EW  = event_width(N);

    // ------------------------------------------------------------------
    // Sample tick
    // ------------------------------------------------------------------
    logic [CW-1:0] cnt_q, cnt_d;
    logic          w_tick;

    assign w_tick = (cnt_q == CW'(DIV - 1));
    assign cnt_d  = w_tick ? '0 : cnt_q + CW'(1);

    // ------------------------------------------------------------------
    // Synchroniser, sample history, debounce state and pending events
    // ------------------------------------------------------------------
    logic [N-1:0]             sync1_q, sync2_q;
    logic [N-1:0][STABLE-1:0] hist_q;
    logic [N-1:0]             state_q, state_d;
    logic [N-1:0]             pend_q, pend_d;
    logic [N-1:0]             ptype_q, ptype_d;
    logic [IW-1:0]            rr_q, rr_d;
    logic                     ovf_q, ovf_d;

    logic [N-1:0]             w_rise;
    logic [N-1:0]             w_fall;
    logic                     w_grant;
    logic [IW-1:0]            w_gidx;

    logic                     w_full;
    logic                     w_empty;
    logic [EW-1:0]            w_head;
    logic [EW-1:0]            w_push_data;

    // A debounced edge needs the whole history window to agree and to
    // differ from the current debounced level.
    always_comb begin
        w_rise = '0;
        w_fall = '0;
        for (int i = 0; i < N; i++) begin
            w_rise[i] = (&hist_q[i]) && !state_q[i];
            w_fall[i] = !(|hist_q[i]) && state_q[i];
        end
    end

    // Round-robin: first pending button at or after rr_q, wrapping.
    // Occupancy is taken before any pop of this cycle, so a full FIFO
    // blocks the push even while the consumer is reading.
    always_comb begin
        w_grant = 1'b0;
        w_gidx  = '0;
        for (int k = 0; k < N; k++) begin
            if (!w_grant && pend_q[(int'(rr_q) + k) % N]) begin
                w_grant = 1'b1;
                w_gidx  = IW'((int'(rr_q) + k) % N);
            end
        end
        if (w_full) begin
            w_grant = 1'b0;
            w_gidx  = '0;
        end
    end

    assign w_push_data = {w_gidx, ptype_q[w_gidx]};

    always_comb begin
        state_d = state_q;
        pend_d  = pend_q;
        ptype_d = ptype_q;
        ovf_d   = ovf_q;
        rr_d    = rr_q;

        if (w_grant) begin
            pend_d[w_gidx] = 1'b0;
            rr_d           = (w_gidx == IW'(N - 1)) ? '0 : w_gidx + IW'(1);
        end

        // A new edge always becomes the pending event. If an older event
        // for the same button is still waiting (and not being pushed right
        // now), it is lost: flag it.
        for (int i = 0; i < N; i++) begin
            if (w_rise[i] || w_fall[i]) begin
                state_d[i] = w_rise[i];
                ptype_d[i] = w_rise[i];
                pend_d[i]  = 1'b1;
                if (pend_q[i] && !(w_grant && (w_gidx == IW'(i)))) begin
                    ovf_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q   <= '0;
            sync1_q <= '0;
            sync2_q <= '0;
            hist_q  <= '0;
            state_q <= '0;
            pend_q  <= '0;
            ptype_q <= '0;
            rr_q    <= '0;
            ovf_q   <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            sync1_q <= ButtonIn;
            sync2_q <= sync1_q;
            if (w_tick) begin
                for (int i = 0; i < N; i++) begin
                    hist_q[i] <= {hist_q[i][STABLE-2:0], sync2_q[i]};
                end
            end
            state_q <= state_d;
            pend_q  <= pend_d;
            ptype_q <= ptype_d;
            rr_q    <= rr_d;
            ovf_q   <= ovf_d;
        end
    end

    // ------------------------------------------------------------------
    // Event FIFO and consumer interface
    // ------------------------------------------------------------------
    event_fifo #(
        .WIDTH (EW),
        .DEPTH (FIFO_DEPTH)
    ) u_event_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (w_grant),
        .data_i  (w_push_data),
        .pop_i   (EventReady),
        .full_o  (w_full),
        .empty_o (w_empty),
        .head_o  (w_head)
    );

    assign EventValid  = !w_empty;
    assign EventId     = w_head[EW-1:1];
    assign EventPress  = w_head[0];
    assign ButtonState = state_q;
    assign Overflow    = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_button_scan_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_button_scan_arbiter
//  Description : Self-checking bench for button_scan_arbiter (N=4, sim tick
//                of 5 clocks, STABLE=4, FIFO_DEPTH=4). A behavioural model
//                tracks each button as "last sample + run length", the FIFO
//                as a queue, and compares every output once per cycle.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_button_scan_arbiter;

    localparam int N      = 4;
    localparam int DIV    = 5;
    localparam int STABLE = 4;
    localparam int DEPTH  = 4;

    logic         clk = 1'b0;
    logic         reset;
    logic [N-1:0] ButtonIn;
    logic [N-1:0] ButtonState;
    logic         EventValid;
    logic         EventReady;
    logic [1:0]   EventId;
    logic         EventPress;
    logic         Overflow;

    always #5 clk = ~clk;

    button_scan_arbiter #(
        .N          (N),
        .CLK_DIV    (500000),
        .SIM_DIV    (DIV),
        .sim        (1),
        .STABLE     (STABLE),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .ButtonIn    (ButtonIn),
        .ButtonState (ButtonState),
        .EventValid  (EventValid),
        .EventReady  (EventReady),
        .EventId     (EventId),
        .EventPress  (EventPress),
        .Overflow    (Overflow)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h, expected %0h", tag, $time, act, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model. Events are encoded as id*2 + press.
    // ------------------------------------------------------------------
    int        m_cnt;
    bit  [N-1:0] m_s1, m_s2;
    bit  [N-1:0] m_last;     // most recent tick sample
    int        m_run [N];    // how many consecutive tick samples equalled m_last
    bit  [N-1:0] m_state, m_pend, m_ptype;
    int        m_rr;
    bit        m_ovf;
    int        m_q[$];       // FIFO contents
    int        obs[$];       // events actually handed to the consumer

    bit        o_valid = 1'b0;
    int        o_evt   = 0;

    task automatic model_step();
        bit          tick;
        bit  [N-1:0] chg;
        bit          grant;
        int          g;
        if (reset) begin
            m_cnt = 0; m_s1 = '0; m_s2 = '0; m_last = '0;
            for (int i = 0; i < N; i++) m_run[i] = STABLE;
            m_state = '0; m_pend = '0; m_ptype = '0; m_rr = 0; m_ovf = 1'b0;
            m_q.delete();
        end else begin
            if (o_valid && EventReady) obs.push_back(o_evt);
            tick = (m_cnt == DIV - 1);
            for (int i = 0; i < N; i++)
                chg[i] = (m_run[i] >= STABLE) && (m_last[i] != m_state[i]);
            grant = 1'b0;
            g     = 0;
            if (m_q.size() < DEPTH) begin
                for (int k = 0; k < N; k++) begin
                    if (!grant && m_pend[(m_rr + k) % N]) begin
                        grant = 1'b1;
                        g     = (m_rr + k) % N;
                    end
                end
            end
            if (m_q.size() != 0 && EventReady) void'(m_q.pop_front());
            if (grant) begin
                m_q.push_back(g * 2 + int'(m_ptype[g]));
                m_pend[g] = 1'b0;
                m_rr      = (g + 1) % N;
            end
            for (int i = 0; i < N; i++) begin
                if (chg[i]) begin
                    if (m_pend[i]) m_ovf = 1'b1;
                    m_state[i] = m_last[i];
                    m_ptype[i] = m_last[i];
                    m_pend[i]  = 1'b1;
                end
            end
            if (tick) begin
                for (int i = 0; i < N; i++) begin
                    if (m_s2[i] == m_last[i]) begin
                        m_run[i] = (m_run[i] + 1 > STABLE) ? STABLE : m_run[i] + 1;
                    end else begin
                        m_last[i] = m_s2[i];
                        m_run[i]  = 1;
                    end
                end
            end
            m_s2  = m_s1;
            m_s1  = ButtonIn;
            m_cnt = tick ? 0 : m_cnt + 1;
        end
    endtask

    always @(posedge clk) model_step();

    // One clock: wait for the falling edge, compare all outputs to the model.
    task automatic cycle();
        @(negedge clk);
        check("state", ButtonState, m_state);
        check("valid", EventValid, m_q.size() != 0);
        if (m_q.size() != 0) check("head", {EventId, EventPress}, m_q[0]);
        check("overflow", Overflow, m_ovf);
        o_valid = EventValid;
        o_evt   = int'({EventId, EventPress});
    endtask

    task automatic run(input int n);
        repeat (n) cycle();
    endtask

    initial begin
        int n;
        int exp4 [6];
        int exp5 [5];

        // 1: reset and idle
        reset = 1'b1; ButtonIn = '0; EventReady = 1'b0;
        run(3);
        reset = 1'b0;
        run(200);
        check("p1_state", ButtonState, 0);
        check("p1_valid", EventValid, 0);
        check("p1_ovf", Overflow, 0);

        // 2: bouncy press then bouncy release on button 1
        obs.delete();
        EventReady = 1'b1;
        for (int c = 0; c < 60; c++) begin
            if (c % 3 == 0) ButtonIn[1] = ~ButtonIn[1];
            cycle();
        end
        ButtonIn[1] = 1'b1;
        run(80);
        check("p2_press_count", obs.size(), 1);
        if (obs.size() >= 1) check("p2_press_evt", obs[0], 3);
        check("p2_state_hi", ButtonState[1], 1);
        for (int c = 0; c < 60; c++) begin
            if (c % 3 == 0) ButtonIn[1] = ~ButtonIn[1];
            cycle();
        end
        ButtonIn[1] = 1'b0;
        run(80);
        check("p2_total_count", obs.size(), 2);
        if (obs.size() >= 2) check("p2_release_evt", obs[1], 2);
        check("p2_state_lo", ButtonState[1], 0);

        // 3: simultaneous presses from rr_ptr = 0
        reset = 1'b1; run(2); reset = 1'b0; run(5);
        obs.delete();
        EventReady = 1'b1;
        ButtonIn   = 4'b1101;
        run(80);
        check("p3_count", obs.size(), 3);
        if (obs.size() == 3) begin
            check("p3_evt0", obs[0], 1);
            check("p3_evt1", obs[1], 5);
            check("p3_evt2", obs[2], 7);
        end
        ButtonIn = 4'b0000;
        run(80);

        // 4: fill FIFO with consumer stalled, two more pending
        obs.delete();
        EventReady = 1'b0;
        ButtonIn   = 4'b1111;
        run(60);
        ButtonIn   = 4'b1100;
        run(80);
        check("p4_valid", EventValid, 1);
        check("p4_head", {EventId, EventPress}, 1);
        check("p4_pending", m_pend, 4'b0011);
        EventReady = 1'b1;
        run(20);
        exp4 = '{1, 3, 5, 7, 0, 2};
        check("p4_count", obs.size(), 6);
        if (obs.size() == 6)
            for (int i = 0; i < 6; i++) check($sformatf("p4_evt%0d", i), obs[i], exp4[i]);
        check("p4_ovf", Overflow, 0);

        // 5: overwrite of a blocked pending event
        EventReady = 1'b0;
        ButtonIn   = 4'b0011;
        run(60);
        ButtonIn[2] = 1'b1;
        run(60);
        check("p5_ovf_before", Overflow, 0);
        ButtonIn[2] = 1'b0;
        run(60);
        check("p5_ovf_after", Overflow, 1);
        obs.delete();
        EventReady = 1'b1;
        run(40);
        exp5 = '{4, 6, 1, 3, 4};
        check("p5_count", obs.size(), 5);
        if (obs.size() == 5)
            for (int i = 0; i < 5; i++) check($sformatf("p5_evt%0d", i), obs[i], exp5[i]);
        check("p5_ovf_sticky", Overflow, 1);

        // 6: reset with FIFO non-empty, button 3 held through reset
        EventReady = 1'b0;
        ButtonIn   = 4'b1011;
        run(60);
        check("p6_fifo_busy", EventValid, 1);
        ButtonIn = 4'b1000;
        reset    = 1'b1;
        cycle();
        check("p6_valid_rst", EventValid, 0);
        check("p6_ovf_rst", Overflow, 0);
        reset = 1'b0;
        EventReady = 1'b1;
        obs.delete();
        n = 0;
        while (!EventValid && n < 100) begin
            cycle();
            n++;
        end
        check("p6_latency", n, 22);
        check("p6_head", {EventId, EventPress}, 7);
        run(10);
        check("p6_count", obs.size(), 1);

        // Random: bursts of bounce, stalls and free-running consumer
        for (int seg = 0; seg < 20; seg++) begin
            int rdy_pct;
            int flip_div;
            rdy_pct  = (seg % 3 == 0) ? 0 : ((seg % 3 == 1) ? 50 : 95);
            flip_div = ($urandom_range(0, 1) == 0) ? 6 : 50;
            for (int c = 0; c < 200; c++) begin
                for (int b = 0; b < N; b++)
                    if ($urandom_range(0, flip_div - 1) == 0) ButtonIn[b] = ~ButtonIn[b];
                EventReady = ($urandom_range(0, 99) < rdy_pct);
                cycle();
            end
        end
        EventReady = 1'b1;
        run(100);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
